// File: rtl/store_monitor_pkg.sv
// store_monitor_pkg: shared definitions for the store-bus monitor.
// Holds the verdict state encodings, default pass/allow constants, bus widths,
// the log-entry payload struct and the store classification helper.
package store_monitor_pkg;

    // Verdict state encodings (RUN is the reset state, the rest are terminal)
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_FAIL    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    // Default signature and scratch address used by the self-checking program
    localparam logic [31:0] DEF_PASS_ADDR  = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA  = 32'd7;
    localparam logic [31:0] DEF_ALLOW_ADDR = 32'd80;

    localparam int unsigned DEF_TIMEOUT   = 1000;
    localparam int unsigned DEF_LOG_DEPTH = 8;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LOG_W   = ADDR_W + DATA_W;
    localparam int unsigned COUNT_W = 16;

    // One logged store
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } log_entry_t;

    // Verdict implied by a single store seen while running
    function automatic logic [1:0] classify_store(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data,
        input logic [ADDR_W-1:0] pass_addr,
        input logic [DATA_W-1:0] pass_data,
        input logic [ADDR_W-1:0] allow_addr
    );
        if ((addr == pass_addr) && (data == pass_data)) begin
            return ST_PASS;
        end
        if (addr != allow_addr) begin
            return ST_FAIL;
        end
        return ST_RUN;
    endfunction

endpackage

// File: rtl/store_monitor_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, reset       - clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_din    - write strobe and data; ignored when full unless a pop
//                      happens on the same edge
//   i_pop            - read strobe; ignored when empty
//   o_dout           - head entry, forced to 0 while empty
//   o_full, o_empty  - occupancy flags
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees the slot the coincident push needs, so full+pop+push is legal
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Storage; contents are don't-care while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    // Fall-through head
    assign o_dout = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/store_monitor.sv
// store_monitor: watches the data-memory write port of the single-cycle core,
// classifies each store against a pass signature and a scratch address, holds
// a sticky pass/fail/timeout verdict and logs stores into a FWFT FIFO.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   memwrite, dataadr, writedata  - store bus from the core
//   done, pass, fail, timeout     - verdict flags (done = any terminal state)
//   store_count                   - saturating count of stores seen while running
//   log_valid, log_ready          - log read handshake (pop on valid & ready)
//   log_addr, log_data            - head entry, 0 while the log is empty
//   log_overflow                  - sticky, a store was dropped on a full log
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR  = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA  = DEF_PASS_DATA,
    parameter logic [31:0] ALLOW_ADDR = DEF_ALLOW_ADDR,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned LOG_DEPTH  = DEF_LOG_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memwrite,
    input  logic [ADDR_W-1:0]   dataadr,
    input  logic [DATA_W-1:0]   writedata,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic [COUNT_W-1:0]  store_count,
    output logic                log_valid,
    input  logic                log_ready,
    output logic [ADDR_W-1:0]   log_addr,
    output logic [DATA_W-1:0]   log_data,
    output logic                log_overflow
);

    localparam int unsigned        TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic [COUNT_W-1:0] r_store_count;
    logic               r_log_overflow;

    logic               w_run;
    logic               w_store;
    logic               w_drop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    log_entry_t         w_push_entry;
    log_entry_t         w_head;

    assign w_run        = (r_state == ST_RUN);
    assign w_store      = w_run & memwrite;
    assign w_push_entry = '{addr: dataadr, data: writedata};

    // A full log only loses the store if the consumer is not popping this edge
    assign w_drop = w_store & w_fifo_full & ~log_ready;

    // Verdict state and timeout counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // Next verdict: a store on the limit edge is classified instead of timing out.
    // The counter parks at its last value so a later idle edge still times out.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        case (r_state)
            ST_RUN: begin
                if (r_tmr != TMR_LAST) begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
                if (memwrite) begin
                    w_state_nxt = classify_store(dataadr, writedata,
                                                 PASS_ADDR, PASS_DATA, ALLOW_ADDR);
                end else if (r_tmr == TMR_LAST) begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    // Saturating store counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_store_count <= '0;
        end else if (w_store && (r_store_count != CNT_MAX)) begin
            r_store_count <= r_store_count + COUNT_W'(1);
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_log_overflow <= 1'b0;
        end else if (w_drop) begin
            r_log_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_store),
        .i_pop   (log_ready),
        .i_din   (w_push_entry),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Outputs decode directly from registered state
    assign pass         = (r_state == ST_PASS);
    assign fail         = (r_state == ST_FAIL);
    assign timeout      = (r_state == ST_TIMEOUT);
    assign done         = ~w_run;
    assign store_count  = r_store_count;
    assign log_overflow = r_log_overflow;
    assign log_valid    = ~w_fifo_empty;
    assign log_addr     = w_head.addr;
    assign log_data     = w_head.data;

endmodule
